// File: rtl/dmux_pkg.sv
// Shared definitions for the registered 1-to-N stream demultiplexer.
// Default sizing plus the one-hot helper that the select decoder is built on.
package dmux_pkg;

    localparam int DMUX_DEF_WIDTH    = 8;
    localparam int DMUX_DEF_SEL_BITS = 3;

    // onehot() returns a fixed, generous width; callers cast it down to their own N_OUT.
    localparam int DMUX_MAX_SEL_BITS = 8;
    localparam int DMUX_MAX_N        = 1 << DMUX_MAX_SEL_BITS;

    function automatic logic [DMUX_MAX_N-1:0] onehot(input int unsigned sel);
        return DMUX_MAX_N'(1) << sel;
    endfunction

endpackage

// File: rtl/dmux_onehot_dec.sv
// Combinational selector-to-one-hot decoder, the select logic of the 1-to-N demux.
// SEL_BITS must not exceed dmux_pkg::DMUX_MAX_SEL_BITS.
module dmux_onehot_dec
    import dmux_pkg::*;
#(
    parameter  int SEL_BITS = DMUX_DEF_SEL_BITS,
    localparam int N_OUT    = 1 << SEL_BITS
) (
    input  logic [SEL_BITS-1:0] sel,
    output logic [N_OUT-1:0]    mask
);

    assign mask = N_OUT'(onehot(32'(sel)));

endmodule

// File: rtl/dmux_stream_1ton.sv
// Registered 1-to-N stream demux: one held word plus a mask of consumers still owed it.
// A word leaves the register only when every targeted consumer has taken it.
module dmux_stream_1ton
    import dmux_pkg::*;
#(
    parameter  int WIDTH    = DMUX_DEF_WIDTH,
    parameter  int SEL_BITS = DMUX_DEF_SEL_BITS,
    localparam int N_OUT    = 1 << SEL_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [SEL_BITS-1:0] in_sel,
    input  logic                in_bcast,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [N_OUT-1:0]    out_valid,
    input  logic [N_OUT-1:0]    out_ready
);

    // Handshake: a transfer happens on any cycle where valid and ready are both high.
    // Valid, once raised, holds with stable data until its transfer; ready never
    // depends on valid of the same port.

    logic [WIDTH-1:0] data_q;
    logic [N_OUT-1:0] pend_q;
    logic [N_OUT-1:0] dec_mask;
    logic [N_OUT-1:0] new_mask;
    logic [N_OUT-1:0] pend_after;
    logic             accept;

    dmux_onehot_dec #(
        .SEL_BITS (SEL_BITS)
    ) u_dec (
        .sel  (in_sel),
        .mask (dec_mask)
    );

    // Bits still owed after this cycle's deliveries; ready on an idle bit clears nothing.
    assign pend_after = pend_q & ~out_ready;

    assign in_ready = !reset && (pend_after == '0);
    assign accept   = in_valid && in_ready;
    assign new_mask = in_bcast ? '1 : dec_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            pend_q <= '0;
        end else if (accept) begin
            data_q <= in_data;
            pend_q <= new_mask;
        end else begin
            pend_q <= pend_after;
        end
    end

    assign out_valid = pend_q;
    assign out_data  = data_q;

    // A consumer that is offered a word keeps seeing it, unchanged, until it takes it.
    for (genvar k = 0; k < N_OUT; k++) begin : g_hold_chk
        a_hold: assert property (@(posedge clk) disable iff (reset)
            (out_valid[k] && !out_ready[k]) |=> (out_valid[k] && $stable(out_data)));
    end

    a_no_ready_in_reset: assert property (@(posedge clk) reset |-> !in_ready);

endmodule

// File: tb/tb_dmux_stream_1ton.sv
// Bench for dmux_stream_1ton: directed cycle table and broadcast drain on the 8-bit/8-way
// instance, plus random traffic on 1-bit/2-way and 32-bit/16-way instances.
module tb_dmux_stream_1ton;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- main 8-bit / 8-way instance ----------------
    logic       reset;
    logic [7:0] in_data;
    logic [2:0] in_sel;
    logic       in_bcast;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic [7:0] out_valid;
    logic [7:0] out_ready;

    dmux_stream_1ton #(.WIDTH(8), .SEL_BITS(3)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_bcast  (in_bcast),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] d;
        logic [2:0] s;
        logic       b;
        logic [7:0] rdy;
        logic       e_ir;
        logic [7:0] e_ov;
        logic [7:0] e_od;
    } vec_t;

    vec_t vt[23];

    task automatic apply(input logic rst, input logic vld, input logic [7:0] d,
                         input logic [2:0] s, input logic b, input logic [7:0] rdy);
        @(posedge clk);
        #1;
        reset     = rst;
        in_valid  = vld;
        in_data   = d;
        in_sel    = s;
        in_bcast  = b;
        out_ready = rdy;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        in_sel    = 3'd0;
        in_bcast  = 1'b0;
        out_ready = 8'h00;

        //          rst   vld   data   sel   bc    rdy     ir    ov     od
        vt[0]  = '{1'b1, 1'b1, 8'hFF, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
        vt[1]  = '{1'b1, 1'b1, 8'hFF, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
        vt[2]  = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'hFF, 1'b1, 8'h00, 8'h00};
        vt[3]  = '{1'b0, 1'b1, 8'hA5, 3'd3, 1'b0, 8'hFF, 1'b1, 8'h00, 8'h00};
        vt[4]  = '{1'b0, 1'b1, 8'h3C, 3'd6, 1'b0, 8'hFF, 1'b1, 8'h08, 8'hA5};
        vt[5]  = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'hFF, 1'b1, 8'h40, 8'h3C};
        vt[6]  = '{1'b0, 1'b1, 8'h11, 3'd5, 1'b0, 8'hFF, 1'b1, 8'h00, 8'h3C};
        vt[7]  = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 8'h20, 8'h11};
        vt[8]  = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 8'h20, 8'h11};
        vt[9]  = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 8'h20, 8'h11};
        vt[10] = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 8'h20, 8'h11};
        vt[11] = '{1'b0, 1'b1, 8'h22, 3'd1, 1'b0, 8'h20, 1'b1, 8'h20, 8'h11};
        vt[12] = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, 8'h02, 8'h22};
        vt[13] = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h02, 1'b1, 8'h02, 8'h22};
        vt[14] = '{1'b0, 1'b1, 8'h7E, 3'd0, 1'b1, 8'h00, 1'b1, 8'h00, 8'h22};
        vt[15] = '{1'b0, 1'b1, 8'h99, 3'd2, 1'b0, 8'h0F, 1'b0, 8'hFF, 8'h7E};
        vt[16] = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'hF0, 1'b1, 8'hF0, 8'h7E};
        vt[17] = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'hFF, 1'b1, 8'h00, 8'h7E};
        vt[18] = '{1'b0, 1'b1, 8'h7E, 3'd5, 1'b1, 8'h00, 1'b1, 8'h00, 8'h7E};
        vt[19] = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h0F, 1'b0, 8'hFF, 8'h7E};
        vt[20] = '{1'b1, 1'b1, 8'h55, 3'd0, 1'b0, 8'h00, 1'b0, 8'hF0, 8'h7E};
        vt[21] = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'hFF, 1'b1, 8'h00, 8'h00};
        vt[22] = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'hFF, 1'b1, 8'h00, 8'h00};

        for (int i = 0; i < 23; i++) begin
            apply(vt[i].rst, vt[i].vld, vt[i].d, vt[i].s, vt[i].b, vt[i].rdy);
            @(negedge clk);
            check($sformatf("row%0d_in_ready", i),  64'(in_ready),  64'(vt[i].e_ir));
            check($sformatf("row%0d_out_valid", i), 64'(out_valid), 64'(vt[i].e_ov));
            check($sformatf("row%0d_out_data", i),  64'(out_data),  64'(vt[i].e_od));
        end

        // Broadcast drained one consumer per cycle, highest index last.
        apply(1'b0, 1'b1, 8'hC3, 3'd2, 1'b1, 8'h00);
        @(negedge clk);
        check("bc_seq_accept", 64'(in_ready), 64'd1);
        apply(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
        @(negedge clk);
        check("bc_seq_full", 64'(out_valid), 64'hFF);
        for (int k = 0; k < 8; k++) begin
            apply(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'(8'h01 << k));
            @(negedge clk);
            check($sformatf("bc_seq%0d_valid", k), 64'(out_valid), 64'(8'(8'hFF << k)));
            check($sformatf("bc_seq%0d_data", k),  64'(out_data),  64'hC3);
            check($sformatf("bc_seq%0d_ready", k), 64'(in_ready),  64'(k == 7));
        end
        apply(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
        @(negedge clk);
        check("bc_seq_empty", 64'(out_valid), 64'h00);

        for (int t = 0; t < 20000; t++) begin
            if (g_sweep[0].done && g_sweep[1].done) break;
            @(posedge clk);
        end
        check("sweep_done", 64'(g_sweep[0].done && g_sweep[1].done), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // ---------------- random-traffic instances ----------------
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int W  = (g == 0) ? 1 : 32;
        localparam int SB = (g == 0) ? 1 : 4;
        localparam int N  = 1 << SB;

        logic          done = 1'b0;
        logic          s_reset;
        logic          s_bcast;
        logic          s_valid;
        logic          s_in_ready;
        logic [W-1:0]  s_data;
        logic [W-1:0]  s_out_data;
        logic [SB-1:0] s_sel;
        logic [N-1:0]  s_out_valid;
        logic [N-1:0]  s_out_ready;

        // Each entry is {still-owed mask, word}; the head is the word currently held.
        logic [N+W-1:0] exp_q[$];

        dmux_stream_1ton #(.WIDTH(W), .SEL_BITS(SB)) u_dut (
            .clk       (clk),
            .reset     (s_reset),
            .in_data   (s_data),
            .in_sel    (s_sel),
            .in_bcast  (s_bcast),
            .in_valid  (s_valid),
            .in_ready  (s_in_ready),
            .out_data  (s_out_data),
            .out_valid (s_out_valid),
            .out_ready (s_out_ready)
        );

        initial begin
            logic [N-1:0] rem;
            logic [N-1:0] rem_n;
            logic [W-1:0] dat;
            logic         exp_rdy;

            s_reset     = 1'b1;
            s_valid     = 1'b0;
            s_bcast     = 1'b0;
            s_data      = '0;
            s_sel       = '0;
            s_out_ready = '0;
            repeat (2) @(posedge clk);
            #1;
            s_reset = 1'b0;

            for (int c = 0; c < 500; c++) begin
                s_valid     = ($urandom_range(0, 3) != 0);
                s_data      = W'($urandom);
                s_sel       = SB'($urandom);
                s_bcast     = ($urandom_range(0, 5) == 0);
                s_out_ready = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom);
                @(negedge clk);

                rem = '0;
                dat = '0;
                if (exp_q.size() > 0) begin
                    rem = exp_q[0][N+W-1:W];
                    dat = exp_q[0][W-1:0];
                end
                rem_n   = rem & ~s_out_ready;
                exp_rdy = (rem_n == '0);

                check($sformatf("sw%0d_c%0d_out_valid", g, c), 64'(s_out_valid), 64'(rem));
                if (rem != '0)
                    check($sformatf("sw%0d_c%0d_out_data", g, c), 64'(s_out_data), 64'(dat));
                check($sformatf("sw%0d_c%0d_in_ready", g, c), 64'(s_in_ready), 64'(exp_rdy));

                if (exp_q.size() > 0) begin
                    if (rem_n == '0) void'(exp_q.pop_front());
                    else exp_q[0] = {rem_n, dat};
                end
                if (s_valid && exp_rdy)
                    exp_q.push_back({(s_bcast ? {N{1'b1}} : N'(N'(1) << s_sel)), s_data});

                @(posedge clk);
                #1;
            end
            s_valid     = 1'b0;
            s_out_ready = '0;
            done        = 1'b1;
        end
    end

endmodule
